// File: rtl/gate_response_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_response_checker_if
// Description : Bundle between a gate bench (master) and the response checker
//               (slave). The master drives the run control and the DUT vector
//               {a, b, out}. The checker returns status, counters and the
//               first-mismatch record.
//   master -> slave : start, op[1:0], vld, a, b, out
//   slave -> master : busy, done, pass, err, vec_cnt, pass_cnt, fail_cnt,
//                     first_fail_idx, first_fail_vec[2:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [1:0]       op;
    logic             vld;
    logic             a;
    logic             b;
    logic             out;
    logic             busy;
    logic             done;
    logic             pass;
    logic             err;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] first_fail_idx;
    logic [2:0]       first_fail_vec;

    modport master (
        output start, op, vld, a, b, out,
        input  busy, done, pass, err, vec_cnt, pass_cnt, fail_cnt,
               first_fail_idx, first_fail_vec
    );

    modport slave (
        input  start, op, vld, a, b, out,
        output busy, done, pass, err, vec_cnt, pass_cnt, fail_cnt,
               first_fail_idx, first_fail_vec
    );
endinterface
`default_nettype wire

// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_response_checker
// Description : Response checker for single-bit two-input gate DUTs. A run is
//               started with start/op, then NUM_VEC vectors {a,b,out} are
//               accepted on vld and compared against the golden function of
//               the latched op (0=AND, 1=OR, 2=XOR, 3=NAND). Pass/fail counts
//               and an overall verdict are reported; all outputs registered.
// Ports       : clk, rst (sync, active-high)
//               bus (gate_response_checker_if.slave):
//                 in : start, op[1:0], vld, a, b, out
//                 out: busy, done, pass, err, vec_cnt, pass_cnt, fail_cnt,
//                      first_fail_idx, first_fail_vec[2:0]
// Config      : GATE_CHK_FIRST_FAIL_EN - builds the first-mismatch capture
//               registers; otherwise first_fail_* read 0 and err tracks
//               fail_cnt != 0.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_response_checker #(
    parameter int NUM_VEC = 5,
    parameter int CNT_W   = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    gate_response_checker_if.slave    bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // vec_cnt value at which the accepted vector is the final one of the run
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_err;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;

    logic             w_expected;
    logic             w_match;
    logic             w_last;

    always_comb begin
        w_expected = 1'b0;
        case (r_op)
            2'd0:    w_expected = bus.a & bus.b;
            2'd1:    w_expected = bus.a | bus.b;
            2'd2:    w_expected = bus.a ^ bus.b;
            default: w_expected = ~(bus.a & bus.b);
        endcase
    end

    assign w_match = (bus.out == w_expected);
    assign w_last  = (r_vec_cnt == c_last_idx);

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] r_ff_idx;
    logic [2:0]       r_ff_vec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_op       <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= 1'b0;
            r_vec_cnt  <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
`ifdef GATE_CHK_FIRST_FAIL_EN
            r_ff_idx   <= '0;
            r_ff_vec   <= 3'b000;
`endif
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    // A vld coinciding with start is deliberately not counted.
                    if (bus.start) begin
                        r_state    <= c_st_run;
                        r_op       <= bus.op;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_err      <= 1'b0;
                        r_vec_cnt  <= '0;
                        r_pass_cnt <= '0;
                        r_fail_cnt <= '0;
`ifdef GATE_CHK_FIRST_FAIL_EN
                        r_ff_idx   <= '0;
                        r_ff_vec   <= 3'b000;
`endif
                    end
                end
                c_st_run: begin
                    // start is ignored here: op stays latched for the run.
                    if (bus.vld) begin
                        r_vec_cnt <= r_vec_cnt + c_one;
                        if (w_match) begin
                            r_pass_cnt <= r_pass_cnt + c_one;
                        end else begin
                            r_fail_cnt <= r_fail_cnt + c_one;
                        end
`ifdef GATE_CHK_FIRST_FAIL_EN
                        // r_err low means no mismatch yet in this run.
                        if (!w_match && !r_err) begin
                            r_err    <= 1'b1;
                            r_ff_idx <= r_vec_cnt;
                            r_ff_vec <= {bus.a, bus.b, bus.out};
                        end
`else
                        // Registered view of (fail_cnt != 0) after this edge.
                        r_err <= (r_fail_cnt != '0) || !w_match;
`endif
                        if (w_last) begin
                            r_state <= c_st_done;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_fail_cnt == '0) && w_match;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;
    assign bus.err      = r_err;
    assign bus.vec_cnt  = r_vec_cnt;
    assign bus.pass_cnt = r_pass_cnt;
    assign bus.fail_cnt = r_fail_cnt;

`ifdef GATE_CHK_FIRST_FAIL_EN
    assign bus.first_fail_idx = r_ff_idx;
    assign bus.first_fail_vec = r_ff_vec;
`else
    assign bus.first_fail_idx = '0;
    assign bus.first_fail_vec = 3'b000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_response_checker
// Description : Self-checking bench for gate_response_checker. A run-level
//               model (list of accepted vectors per run) predicts all outputs
//               and is compared every cycle; directed scenarios add literal
//               expectations for the verdicts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_response_checker;

    localparam int NUM_VEC = 5;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gate_response_checker_if #(.CNT_W(CNT_W)) bus ();

    gate_response_checker #(
        .NUM_VEC (NUM_VEC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- run-level model ----------------
    bit         m_cmp_en = 1'b0;
    bit         m_active = 1'b0;
    bit         m_done   = 1'b0;
    logic [1:0] m_op     = 2'd0;
    logic [2:0] m_q[$];

    function automatic logic golden(input logic [1:0] o, input logic a, input logic b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cmp_en = 1'b1;
            m_active = 1'b0;
            m_done   = 1'b0;
            m_q.delete();
        end else if (!m_active) begin
            if (bus.start) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_op     = bus.op;
                m_q.delete();
            end
        end else if (bus.vld) begin
            m_q.push_back({bus.a, bus.b, bus.out});
            if (m_q.size() == NUM_VEC) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int         np;
        int         nf;
        int         ffi;
        logic [2:0] ffv;
        if (m_cmp_en) begin
            np  = 0;
            nf  = 0;
            ffi = 0;
            ffv = 3'b000;
            for (int i = 0; i < m_q.size(); i++) begin
                if (m_q[i][0] == golden(m_op, m_q[i][2], m_q[i][1])) begin
                    np++;
                end else begin
                    if (nf == 0) begin
                        ffi = i;
                        ffv = m_q[i];
                    end
                    nf++;
                end
            end
            chk("busy",     int'(bus.busy),     int'(m_active));
            chk("done",     int'(bus.done),     int'(m_done));
            chk("pass",     int'(bus.pass),     int'(m_done && nf == 0));
            chk("err",      int'(bus.err),      int'(nf != 0));
            chk("vec_cnt",  int'(bus.vec_cnt),  m_q.size());
            chk("pass_cnt", int'(bus.pass_cnt), np);
            chk("fail_cnt", int'(bus.fail_cnt), nf);
`ifdef GATE_CHK_FIRST_FAIL_EN
            chk("first_fail_idx", int'(bus.first_fail_idx), ffi);
            chk("first_fail_vec", int'(bus.first_fail_vec), int'(ffv));
`else
            chk("first_fail_idx", int'(bus.first_fail_idx), 0);
            chk("first_fail_vec", int'(bus.first_fail_vec), 0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic [1:0] o, input logic v, input logic [2:0] abo);
        bus.start = s;
        bus.op    = o;
        bus.vld   = v;
        {bus.a, bus.b, bus.out} = abo;
        @(negedge clk);
    endtask

    task automatic run5(input logic [1:0] o, input logic [2:0] v [5]);
        cyc(1'b1, o, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) cyc(1'b0, o, 1'b1, v[i]);
    endtask

    logic [2:0] v_and_ok [5] = '{3'b000, 3'b010, 3'b100, 3'b111, 3'b000};
    logic [2:0] v_and_bad[5] = '{3'b000, 3'b011, 3'b100, 3'b111, 3'b001};
    logic [2:0] v_xor    [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b000};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.vld   = 1'b0;
        bus.a     = 1'b0;
        bus.b     = 1'b0;
        bus.out   = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_vec",  int'(bus.vec_cnt), 0);
        rst = 1'b0;
        cyc(1'b0, 2'd0, 1'b1, 3'b001); // vld in IDLE is ignored
        chk("idle_vld_vec", int'(bus.vec_cnt), 0);

        // AND, all good
        run5(2'd0, v_and_ok);
        chk("and_done", int'(bus.done), 1);
        chk("and_pass", int'(bus.pass), 1);
        chk("and_pcnt", int'(bus.pass_cnt), 5);
        chk("and_fcnt", int'(bus.fail_cnt), 0);
        chk("and_err",  int'(bus.err), 0);
        cyc(1'b0, 2'd0, 1'b0, 3'b000);

        // AND with two injected faults (indices 1 and 4)
        run5(2'd0, v_and_bad);
        chk("flt_fcnt", int'(bus.fail_cnt), 2);
        chk("flt_pcnt", int'(bus.pass_cnt), 3);
        chk("flt_pass", int'(bus.pass), 0);
        chk("flt_err",  int'(bus.err), 1);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk("flt_ffidx", int'(bus.first_fail_idx), 1);
        chk("flt_ffvec", int'(bus.first_fail_vec), 3);
`endif

        // XOR all good
        run5(2'd2, v_xor);
        chk("xor_pass", int'(bus.pass), 1);
        // NAND on the same vectors: 000 and the final 000 expect out=1 (fail);
        // 011, 101 (exp 1) and 110 (exp 0) match.
        run5(2'd3, v_xor);
        chk("nand_fcnt", int'(bus.fail_cnt), 2);
        chk("nand_pcnt", int'(bus.pass_cnt), 3);
        chk("nand_pass", int'(bus.pass), 0);

        // OR run with gaps and a mid-run start trying to switch to NAND
        cyc(1'b1, 2'd1, 1'b0, 3'b000);
        cyc(1'b0, 2'd1, 1'b1, 3'b000);
        cyc(1'b0, 2'd1, 1'b0, 3'b000);
        cyc(1'b0, 2'd1, 1'b1, 3'b011);
        cyc(1'b1, 2'd3, 1'b0, 3'b000);
        chk("gap_mid_vec",  int'(bus.vec_cnt), 2);
        chk("gap_mid_busy", int'(bus.busy), 1);
        cyc(1'b0, 2'd1, 1'b1, 3'b101);
        cyc(1'b0, 2'd1, 1'b0, 3'b000);
        cyc(1'b0, 2'd1, 1'b1, 3'b111);
        chk("gap_4_busy", int'(bus.busy), 1);
        cyc(1'b0, 2'd1, 1'b0, 3'b000);
        cyc(1'b0, 2'd1, 1'b1, 3'b111); // NAND(1,1)=0 would fail here
        chk("gap_done", int'(bus.done), 1);
        chk("gap_vec",  int'(bus.vec_cnt), 5);
        chk("gap_pass", int'(bus.pass), 1);
        cyc(1'b0, 2'd1, 1'b1, 3'b001);
        chk("done_vld_vec", int'(bus.vec_cnt), 5);

        // reset mid-run after three vectors
        cyc(1'b1, 2'd0, 1'b0, 3'b000);
        cyc(1'b0, 2'd0, 1'b1, 3'b000);
        cyc(1'b0, 2'd0, 1'b1, 3'b011);
        cyc(1'b0, 2'd0, 1'b1, 3'b100);
        rst = 1'b1;
        cyc(1'b0, 2'd0, 1'b1, 3'b111);
        rst = 1'b0;
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_vec",  int'(bus.vec_cnt), 0);
        chk("mrst_fcnt", int'(bus.fail_cnt), 0);
        chk("mrst_err",  int'(bus.err), 0);
        run5(2'd0, v_and_ok);
        chk("mrst_pass", int'(bus.pass), 1);

        // back-to-back: start with vld in DONE
        cyc(1'b1, 2'd2, 1'b1, 3'b001);
        chk("b2b_vec",  int'(bus.vec_cnt), 0);
        chk("b2b_busy", int'(bus.busy), 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'd2, 1'b1, v_xor[i]);
        chk("b2b_4_done", int'(bus.done), 0);
        chk("b2b_4_vec",  int'(bus.vec_cnt), 4);
        cyc(1'b0, 2'd2, 1'b1, v_xor[4]);
        chk("b2b_done", int'(bus.done), 1);
        chk("b2b_pass", int'(bus.pass), 1);
        cyc(1'b0, 2'd0, 1'b0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
